mips_mem: RTL and testbench
===========================

// Module: mips_mem
// PURPOSE
//  Memory-side responder for the multicycle mips core: unified instruction/data memory plus instruction register.
//  Muxes the core's pc/aluout by iord, serves readdata combinationally, commits stores on memwrite, and
//  latches instr on irwrite. Also provides a testbench preload port, a sticky bus-error flag and access counters.
// PARAMETERS
//  DEPTH     256  number of 32-bit words; byte address range 0 .. 4*DEPTH-1
//  ADDR_W    8    word-index width, $clog2(DEPTH)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       asynchronous, active-high reset
//  pc         in   32      core fetch byte address
//  aluout     in   32      core data byte address
//  writedata  in   32      core store data
//  iord       in   1       0: address = pc, 1: address = aluout
//  memwrite   in   1       store strobe, one word per asserted cycle
//  irwrite    in   1       instruction-register load strobe
//  ld_en      in   1       preload write enable (testbench/boot)
//  ld_addr    in   ADDR_W  preload word index
//  ld_data    in   32      preload word
//  instr      out  32      instruction register to core
//  readdata   out  32      combinational read data to core
//  bus_err    out  1       sticky error flag
//  fetch_cnt  out  32      number of accepted irwrite cycles
//  store_cnt  out  32      number of committed core stores
// BEHAVIOUR
//  - addr = iord ? aluout : pc; idx = addr[ADDR_W+1:2]; in_range = (addr < 4*DEPTH); aligned = (addr[1:0]==0).
//  - readdata = in_range ? mem[idx] : 32'h0, purely combinational, same cycle (zero latency), also during reset.
//  - Reset (async, asserted): instr=0 (nop), bus_err=0, fetch_cnt=0, store_cnt=0; memory array NOT cleared.
//  - While reset high: core strobes (memwrite, irwrite) ignored; ld_en still writes mem[ld_addr] each edge.
//  - Preload: ld_en=1 -> mem[ld_addr] <= ld_data at edge; has priority over a core store in the same cycle
//    (core store dropped, store_cnt not incremented, bus_err unchanged).
//  - Store: memwrite & in_range & aligned & !ld_en & !reset -> mem[idx] <= writedata; store_cnt += 1.
//  - Store with !in_range or !aligned: memory unchanged, store_cnt unchanged, bus_err <= 1.
//  - Fetch: irwrite & !reset -> instr <= readdata (value BEFORE any same-cycle store: read-before-write);
//    fetch_cnt += 1. instr holds its value in every cycle irwrite=0.
//  - Fetch with !in_range or !aligned: instr <= 32'h0 (for !in_range) or mem[idx] (misaligned, truncated index);
//    bus_err <= 1. Fetch with iord=1 is legal (no error).
//  - Misaligned read without irwrite/memwrite raises no error (core drives aluout freely between states).
//  - irwrite and memwrite in same cycle: both take effect per above; counters each increment independently.
//  - bus_err stays 1 until reset. Counters wrap 32'hFFFF_FFFF -> 0 with no flag.
//  - Reset asserted mid-operation: outputs clear immediately (asynchronously); a store/fetch on that edge is lost;
//    memory contents from earlier completed writes are retained.
//  - Single-cycle write port, single combinational read port; no stalls, no handshake toward the core.
// TESTING
//  1 Hold reset, preload mem[0]=0x2002_0005, mem[1]=0xAC02_0040; release; pc=0, irwrite=1 -> instr=0x2002_0005 next edge, fetch_cnt=1.
//  2 iord=1, aluout=0x40, writedata=0xDEAD_BEEF, memwrite=1 one cycle -> readdata=0xDEAD_BEEF after edge, store_cnt=1, bus_err=0.
//  3 pc=aluout=0x8, iord=0, mem[2]=0x1111_1111, irwrite=1 & memwrite=1 (writedata=0x2222_2222) -> instr=0x1111_1111, mem[2]=0x2222_2222.
//  4 memwrite at aluout=0x400 (DEPTH=256) -> no write, readdata=0, bus_err=1 and stays 1; misaligned store 0x42 -> mem[0x10] unchanged.
//  5 ld_en=1 ld_addr=3 ld_data=0xA5A5_A5A5 with memwrite to 0xC same cycle -> mem[3]=0xA5A5_A5A5, store_cnt unchanged.
//  6 Assert reset between edges after instr loaded -> instr=0, counters=0, bus_err=0 immediately; mem[0] still 0x2002_0005.

Source files
------------

// File: rtl/mips_mem_if.sv
// Core-facing bus of the multicycle mips memory: fetch/data addressing, store path,
// instruction register, preload port and status outputs.
interface mips_mem_if #(
  parameter int ADDR_W = 8
);
  logic [31:0]       pc;
  logic [31:0]       aluout;
  logic [31:0]       writedata;
  logic              iord;
  logic              memwrite;
  logic              irwrite;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic [31:0]       instr;
  logic [31:0]       readdata;
  logic              bus_err;
  logic [31:0]       fetch_cnt;
  logic [31:0]       store_cnt;

  modport master (
    output pc, aluout, writedata, iord, memwrite, irwrite,
    output ld_en, ld_addr, ld_data,
    input  instr, readdata, bus_err, fetch_cnt, store_cnt
  );

  modport slave (
    input  pc, aluout, writedata, iord, memwrite, irwrite,
    input  ld_en, ld_addr, ld_data,
    output instr, readdata, bus_err, fetch_cnt, store_cnt
  );
endinterface

// File: rtl/mips_mem.sv
// Unified instruction/data memory with instruction register for the multicycle mips core,
// plus preload port, sticky bus-error flag and fetch/store counters.
module mips_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  mips_mem_if.slave   bus
);

  localparam logic [32:0] MEM_BYTES = 33'(4 * DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [31:0]       addr;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              aligned;
  logic              access_ok;
  logic              store_en;
  logic              store_req;

  logic [31:0]       instr_r;
  logic              bus_err_r;
  logic [31:0]       fetch_cnt_r;
  logic [31:0]       store_cnt_r;

  // Address decode and combinational read port
  assign addr      = bus.iord ? bus.aluout : bus.pc;
  assign idx       = addr[ADDR_W+1:2];
  assign in_range  = ({1'b0, addr} < MEM_BYTES);
  assign aligned   = (addr[1:0] == 2'b00);
  assign access_ok = in_range & aligned;

  assign bus.readdata = in_range ? mem[idx] : 32'h0;

  // A core store only competes for the write port when no preload is pending.
  assign store_req = bus.memwrite & ~bus.ld_en;
  assign store_en  = store_req & access_ok & ~reset;

  // Single write port: preload wins over a core store; preload also runs during reset.
  always_ff @(posedge clk) begin
    if (bus.ld_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end else if (store_en) begin
      mem[idx] <= bus.writedata;
    end
  end

  // Instruction register, sticky error and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r     <= 32'h0;
      bus_err_r   <= 1'b0;
      fetch_cnt_r <= 32'h0;
      store_cnt_r <= 32'h0;
    end else begin
      if (bus.irwrite) begin
        // readdata still reflects the pre-store contents here (read-before-write).
        instr_r     <= bus.readdata;
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
        if (!access_ok) begin
          bus_err_r <= 1'b1;
        end
      end
      if (store_req) begin
        if (access_ok) begin
          store_cnt_r <= store_cnt_r + 32'd1;
        end else begin
          bus_err_r <= 1'b1;
        end
      end
    end
  end

  assign bus.instr     = instr_r;
  assign bus.bus_err   = bus_err_r;
  assign bus.fetch_cnt = fetch_cnt_r;
  assign bus.store_cnt = store_cnt_r;

endmodule

// File: tb/tb_mips_mem.sv
// Self-checking bench for mips_mem: directed scenarios plus randomized traffic against
// a word-array reference model.
module tb_mips_mem;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_mem_if #(.ADDR_W(ADDR_W)) bus();
  mips_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr, m_fc, m_sc;
  logic        m_err;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a < 32'(4 * DEPTH)) return m_mem[a / 4];
    return 32'h0;
  endfunction

  function automatic bit m_ok(input logic [31:0] a);
    return (a < 32'(4 * DEPTH)) && (a % 4 == 0);
  endfunction

  task automatic idle();
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.ld_en    = 1'b0;
  endtask

  task automatic clear_model();
    m_instr = 32'h0;
    m_err   = 1'b0;
    m_fc    = 32'h0;
    m_sc    = 32'h0;
  endtask

  // One clock edge: model next state from the inputs seen at the edge, then commit.
  task automatic cycle();
    logic [31:0] a, rd, n_instr, n_fc, n_sc, wd, ldd;
    logic [ADDR_W-1:0] lda;
    logic n_err, do_ld, do_st, rst_now;
    a       = bus.iord ? bus.aluout : bus.pc;
    rd      = m_read(a);
    n_instr = m_instr; n_fc = m_fc; n_sc = m_sc; n_err = m_err;
    do_ld   = bus.ld_en; lda = bus.ld_addr; ldd = bus.ld_data; wd = bus.writedata;
    rst_now = reset;
    do_st   = 1'b0;
    if (!rst_now) begin
      if (bus.irwrite) begin
        n_instr = rd;
        n_fc    = m_fc + 1;
        if (!m_ok(a)) n_err = 1'b1;
      end
      if (bus.memwrite && !do_ld) begin
        if (m_ok(a)) begin
          do_st = 1'b1;
          n_sc  = m_sc + 1;
        end else begin
          n_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (do_ld) m_mem[lda] = ldd;
    else if (do_st) m_mem[a / 4] = wd;
    if (rst_now) clear_model();
    else begin
      m_instr = n_instr; m_fc = n_fc; m_sc = n_sc; m_err = n_err;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.pc = 32'h0; bus.aluout = 32'h0; bus.iord = 1'b0; bus.writedata = 32'h0;
    bus.ld_addr = '0; bus.ld_data = 32'h0;
    clear_model();
    #2;
    tests++;
    if (bus.instr !== 32'h0 || bus.bus_err !== 1'b0 || bus.fetch_cnt !== 32'h0 || bus.store_cnt !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: instr=%h err=%b fc=%0d sc=%0d, required all zero",
               bus.instr, bus.bus_err, bus.fetch_cnt, bus.store_cnt);
    end
    // Fill every word while reset is held; core strobes must be ignored meanwhile.
    for (int i = 0; i < DEPTH; i++) begin
      bus.ld_en = 1'b1; bus.ld_addr = ADDR_W'(i); bus.ld_data = $urandom;
      bus.irwrite = 1'b1;
      cycle();
    end
    idle();
    bus.memwrite = 1'b1; bus.irwrite = 1'b1; bus.pc = 32'h4; bus.writedata = 32'h1234_5678;
    cycle();
    idle();
    #1;
    tests++;
    if (bus.instr !== 32'h0 || bus.fetch_cnt !== 32'h0 || bus.store_cnt !== 32'h0 || bus.readdata !== m_mem[1]) begin
      fails++;
      $display("FAIL reset_strobes_ignored: instr=%h fc=%0d sc=%0d rd=%h, required 0/0/0/%h",
               bus.instr, bus.fetch_cnt, bus.store_cnt, bus.readdata, m_mem[1]);
    end
  endtask

  task automatic test_fetch();
    bus.ld_en = 1'b1; bus.ld_addr = 8'd0; bus.ld_data = 32'h2002_0005;
    cycle();
    bus.ld_addr = 8'd1; bus.ld_data = 32'hAC02_0040;
    cycle();
    idle();
    reset = 1'b0;
    bus.pc = 32'h0; bus.iord = 1'b0;
    #1;
    tests++;
    if (bus.readdata !== 32'h2002_0005) begin
      fails++;
      $display("FAIL fetch_readdata: got %h, required 20020005", bus.readdata);
    end
    bus.irwrite = 1'b1;
    cycle();
    idle();
    tests++;
    if (bus.instr !== 32'h2002_0005 || bus.fetch_cnt !== 32'd1) begin
      fails++;
      $display("FAIL fetch_instr: instr=%h fc=%0d, required 20020005/1", bus.instr, bus.fetch_cnt);
    end
    bus.pc = 32'h4;
    cycle();
    tests++;
    if (bus.instr !== 32'h2002_0005 || bus.readdata !== 32'hAC02_0040) begin
      fails++;
      $display("FAIL fetch_hold: instr=%h rd=%h, required 20020005/ac020040", bus.instr, bus.readdata);
    end
  endtask

  task automatic test_store();
    bus.iord = 1'b1; bus.aluout = 32'h40; bus.writedata = 32'hDEAD_BEEF; bus.memwrite = 1'b1;
    cycle();
    idle();
    #1;
    tests++;
    if (bus.readdata !== 32'hDEAD_BEEF || bus.store_cnt !== 32'd1 || bus.bus_err !== 1'b0) begin
      fails++;
      $display("FAIL store_basic: rd=%h sc=%0d err=%b, required deadbeef/1/0",
               bus.readdata, bus.store_cnt, bus.bus_err);
    end
  endtask

  task automatic test_fetch_store_same();
    bus.ld_en = 1'b1; bus.ld_addr = 8'd2; bus.ld_data = 32'h1111_1111;
    cycle();
    idle();
    bus.pc = 32'h8; bus.aluout = 32'h8; bus.iord = 1'b0;
    bus.irwrite = 1'b1; bus.memwrite = 1'b1; bus.writedata = 32'h2222_2222;
    cycle();
    idle();
    #1;
    tests++;
    if (bus.instr !== 32'h1111_1111 || bus.readdata !== 32'h2222_2222) begin
      fails++;
      $display("FAIL fetch_store_same: instr=%h rd=%h, required 11111111/22222222", bus.instr, bus.readdata);
    end
    tests++;
    if (bus.fetch_cnt !== 32'd2 || bus.store_cnt !== 32'd2) begin
      fails++;
      $display("FAIL fetch_store_counts: fc=%0d sc=%0d, required 2/2", bus.fetch_cnt, bus.store_cnt);
    end
  endtask

  task automatic test_out_of_range();
    bus.iord = 1'b1; bus.aluout = 32'h400; bus.writedata = 32'h5555_AAAA; bus.memwrite = 1'b1;
    cycle();
    idle();
    #1;
    tests++;
    if (bus.readdata !== 32'h0 || bus.bus_err !== 1'b1 || bus.store_cnt !== 32'd2) begin
      fails++;
      $display("FAIL store_oob: rd=%h err=%b sc=%0d, required 0/1/2", bus.readdata, bus.bus_err, bus.store_cnt);
    end
    tests++;
    if (dut.mem[0] !== 32'h2002_0005) begin
      fails++;
      $display("FAIL store_oob_alias: mem[0]=%h, required 20020005", dut.mem[0]);
    end
    bus.aluout = 32'h42; bus.memwrite = 1'b1;
    cycle();
    idle();
    bus.aluout = 32'h40;
    #1;
    tests++;
    if (bus.readdata !== 32'hDEAD_BEEF || bus.bus_err !== 1'b1 || bus.store_cnt !== 32'd2) begin
      fails++;
      $display("FAIL store_misaligned: rd=%h err=%b sc=%0d, required deadbeef/1/2",
               bus.readdata, bus.bus_err, bus.store_cnt);
    end
    cycle();
    tests++;
    if (bus.bus_err !== 1'b1) begin
      fails++;
      $display("FAIL bus_err_sticky: got %b, required 1", bus.bus_err);
    end
  endtask

  task automatic test_preload_priority();
    bus.ld_en = 1'b1; bus.ld_addr = 8'd3; bus.ld_data = 32'hA5A5_A5A5;
    bus.iord = 1'b1; bus.aluout = 32'hC; bus.writedata = 32'h0BAD_F00D; bus.memwrite = 1'b1;
    cycle();
    idle();
    #1;
    tests++;
    if (bus.readdata !== 32'hA5A5_A5A5 || bus.store_cnt !== 32'd2) begin
      fails++;
      $display("FAIL preload_priority: rd=%h sc=%0d, required a5a5a5a5/2", bus.readdata, bus.store_cnt);
    end
  endtask

  task automatic test_async_reset();
    bus.iord = 1'b0; bus.pc = 32'h0; bus.irwrite = 1'b1;
    cycle();
    idle();
    tests++;
    if (bus.instr !== 32'h2002_0005) begin
      fails++;
      $display("FAIL async_reset_setup: instr=%h, required 20020005", bus.instr);
    end
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    tests++;
    if (bus.instr !== 32'h0 || bus.bus_err !== 1'b0 || bus.fetch_cnt !== 32'h0 ||
        bus.store_cnt !== 32'h0 || bus.readdata !== 32'h2002_0005) begin
      fails++;
      $display("FAIL async_reset: instr=%h err=%b fc=%0d sc=%0d rd=%h, required 0/0/0/0/20020005",
               bus.instr, bus.bus_err, bus.fetch_cnt, bus.store_cnt, bus.readdata);
    end
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    logic [31:0] a, exp_rd;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h400 + $urandom_range(0, 32'hFFFF);
        1:       a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
        default: a = $urandom_range(0, DEPTH - 1) * 4;
      endcase
      bus.iord = 1'($urandom_range(0, 1));
      if (bus.iord) begin
        bus.aluout = a; bus.pc = $urandom_range(0, DEPTH - 1) * 4;
      end else begin
        bus.pc = a; bus.aluout = $urandom;
      end
      bus.irwrite   = ($urandom_range(0, 1) == 1);
      bus.memwrite  = ($urandom_range(0, 2) == 0);
      bus.writedata = $urandom;
      bus.ld_en     = ($urandom_range(0, 7) == 0);
      bus.ld_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.ld_data   = $urandom;
      #1;
      exp_rd = m_read(a);
      tests++;
      if (bus.readdata !== exp_rd) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL rand_readdata[%0d]: got %h, required %h", n, bus.readdata, exp_rd);
      end
      cycle();
      tests++;
      if (bus.instr !== m_instr || bus.bus_err !== m_err || bus.fetch_cnt !== m_fc || bus.store_cnt !== m_sc) begin
        fails++; errs++;
        if (errs < 10)
          $display("FAIL rand_state[%0d]: instr=%h err=%b fc=%0d sc=%0d, required %h/%b/%0d/%0d",
                   n, bus.instr, bus.bus_err, bus.fetch_cnt, bus.store_cnt, m_instr, m_err, m_fc, m_sc);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_fetch_store_same();
    test_out_of_range();
    test_preload_priority();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
